mnist_frame_loader: RTL and testbench

Upstream sequencer for the inference core: accepts a framed pixel stream from the UART receiver and writes 784 pixels into the image buffer. It then drives the level-sensitive `start` of the control FSM and holds it until `done`. When `done` arrives it latches the predicted digit and returns it as an ASCII byte to the UART transmitter. It owns the frame/handshake protocol between the host link and the compute datapath.

---
 rtl/mnist_frame_loader.sv | 178 +++++++++++++++++
 tb/tb_mnist_frame_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mnist_frame_loader.sv
// Frame sequencer between the UART link and the inference core: collects one
// sync-framed image into the image buffer, runs the core and reports the digit.
module mnist_frame_loader #(
  parameter int unsigned N_PIX     = 784,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       img_we,
  output logic [9:0] img_addr,
  output logic [7:0] img_wdata,
  output logic       start,
  input  logic       done,
  input  logic [3:0] pred_in,
  output logic [3:0] pred_out,
  output logic       pred_valid,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       frame_err,
  output logic       loader_busy
);

  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [9:0]      LAST_PIX = 10'(N_PIX - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RECV    = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  logic [2:0]      state_q,     state_d;
  logic [9:0]      pix_cnt_q,   pix_cnt_d;
  logic [TO_W-1:0] to_cnt_q,    to_cnt_d;
  logic            img_we_q,    img_we_d;
  logic [9:0]      img_addr_q,  img_addr_d;
  logic [7:0]      img_wdata_q, img_wdata_d;
  logic            start_q,     start_d;
  logic [3:0]      pred_out_q,  pred_out_d;
  logic            pred_vld_q,  pred_vld_d;
  logic            tx_valid_q,  tx_valid_d;
  logic [7:0]      tx_data_q,   tx_data_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q,      busy_d;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    to_cnt_d    = to_cnt_q;
    img_we_d    = 1'b0;
    img_addr_d  = img_addr_q;
    img_wdata_d = img_wdata_q;
    start_d     = start_q;
    pred_out_d  = pred_out_q;
    pred_vld_d  = pred_vld_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d   = S_RECV;
          pix_cnt_d = '0;
          to_cnt_d  = '0;
        end
      end

      // Inside a frame every byte is payload, including one equal to the sync byte.
      S_RECV: begin
        if (rx_valid) begin
          img_we_d    = 1'b1;
          img_addr_d  = pix_cnt_q;
          img_wdata_d = rx_data;
          pix_cnt_d   = pix_cnt_q + 10'd1;
          to_cnt_d    = '0;
          if (pix_cnt_q == LAST_PIX) begin
            state_d = S_FLUSH;
          end
        end else if (to_cnt_q == TO_LAST) begin
          frame_err_d = 1'b1;
          to_cnt_d    = '0;
          state_d     = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_FLUSH: begin
        start_d = 1'b1;
        state_d = S_RUN;
      end

      S_RUN: begin
        if (done) begin
          pred_out_d = pred_in;
          pred_vld_d = 1'b1;
          start_d    = 1'b0;
          tx_data_d  = 8'h30 + {4'h0, pred_in};
          tx_valid_d = 1'b1;
          state_d    = S_REPORT;
        end
      end

      S_REPORT: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_RELEASE;
        end
      end

      // A done still high from the previous run must not complete the next frame.
      S_RELEASE: begin
        if (!done) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        start_d    = 1'b0;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      to_cnt_q    <= '0;
      img_we_q    <= 1'b0;
      img_addr_q  <= '0;
      img_wdata_q <= '0;
      start_q     <= 1'b0;
      pred_out_q  <= '0;
      pred_vld_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      to_cnt_q    <= to_cnt_d;
      img_we_q    <= img_we_d;
      img_addr_q  <= img_addr_d;
      img_wdata_q <= img_wdata_d;
      start_q     <= start_d;
      pred_out_q  <= pred_out_d;
      pred_vld_q  <= pred_vld_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign img_we      = img_we_q;
  assign img_addr    = img_addr_q;
  assign img_wdata   = img_wdata_q;
  assign start       = start_q;
  assign pred_out    = pred_out_q;
  assign pred_valid  = pred_vld_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign frame_err   = frame_err_q;
  assign loader_busy = busy_q;

endmodule

// File: tb/tb_mnist_frame_loader.sv
// Bench for mnist_frame_loader: a transaction-level model checked every cycle,
// plus hand-computed literal expectations at the protocol milestones.
module tb_mnist_frame_loader;

  localparam int TO   = 16;
  localparam int NPIX = 784;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       done = 1'b0;
  logic [3:0] pred_in = 4'h0;
  logic       tx_ready = 1'b0;
  logic       img_we;
  logic [9:0] img_addr;
  logic [7:0] img_wdata;
  logic       start;
  logic [3:0] pred_out;
  logic       pred_valid;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       frame_err;
  logic       loader_busy;

  always #5 clk = ~clk;

  mnist_frame_loader #(.N_PIX(NPIX), .SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
    .start(start), .done(done), .pred_in(pred_in), .pred_out(pred_out),
    .pred_valid(pred_valid), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .frame_err(frame_err), .loader_busy(loader_busy)
  );

  // Model: where in the frame protocol we are, how many pixels have arrived,
  // and how long the link has been silent; outputs follow one edge later.
  localparam int P_IDLE = 0, P_RECV = 1, P_FLUSH = 2, P_RUN = 3, P_REPORT = 4, P_RELEASE = 5;
  int         mPhase = P_IDLE;
  int         mCount = 0;
  int         mGap = 0;
  logic       eWe = 1'b0, eStart = 1'b0, ePv = 1'b0, eTxV = 1'b0, eErr = 1'b0;
  logic [9:0] eAddr = '0;
  logic [7:0] eData = '0, eTx = '0;
  logic [3:0] ePred = '0;
  logic       eBusy;
  assign eBusy = (mPhase != P_IDLE);

  always @(posedge clk) begin
    eWe  <= 1'b0;
    eErr <= 1'b0;
    if (rst) begin
      mPhase <= P_IDLE; mCount <= 0; mGap <= 0;
      eAddr <= '0; eData <= '0; eStart <= 1'b0; ePred <= '0;
      ePv <= 1'b0; eTxV <= 1'b0; eTx <= '0;
    end else begin
      case (mPhase)
        P_IDLE: if (rx_valid && rx_data == 8'hA5) begin
          mPhase <= P_RECV; mCount <= 0; mGap <= 0;
        end
        P_RECV: if (rx_valid) begin
          eWe <= 1'b1; eAddr <= 10'(mCount); eData <= rx_data;
          mCount <= mCount + 1; mGap <= 0;
          if (mCount + 1 == NPIX) mPhase <= P_FLUSH;
        end else if (mGap + 1 == TO) begin
          eErr <= 1'b1; mPhase <= P_IDLE;
        end else begin
          mGap <= mGap + 1;
        end
        P_FLUSH: begin eStart <= 1'b1; mPhase <= P_RUN; end
        P_RUN: if (done) begin
          ePred <= pred_in; ePv <= 1'b1; eStart <= 1'b0;
          eTx <= 8'h30 + {4'h0, pred_in}; eTxV <= 1'b1; mPhase <= P_REPORT;
        end
        P_REPORT: if (tx_ready) begin eTxV <= 1'b0; mPhase <= P_RELEASE; end
        P_RELEASE: if (!done) mPhase <= P_IDLE;
        default: mPhase <= P_IDLE;
      endcase
    end
  end

  int         nChecks = 0;
  int         nPass = 0;
  bit         armed = 1'b0;
  int         weCount = 0;
  int         startRises = 0;
  logic       startPrev = 1'b0;
  logic [7:0] pix165 = 8'h00;
  int         riseSnap;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  // Every cycle: compare all outputs with the model, then update monitors.
  task automatic tick;
    @(posedge clk);
    #1;
    if (armed)
      checkOutput("cycle_outputs",
        {28'd0, img_we, img_addr, img_wdata, start, pred_out, pred_valid, tx_valid, tx_data, frame_err, loader_busy},
        {28'd0, eWe, eAddr, eData, eStart, ePred, ePv, eTxV, eTx, eErr, eBusy});
    if (img_we) begin
      weCount++;
      if (img_addr == 10'd165) pix165 = img_wdata;
    end
    if (start && !startPrev) startRises++;
    startPrev = start;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
  endtask

  task automatic idleCycles(input int n);
    rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    armed = 1'b1;
    checkOutput("reset_start", start, 0);
    checkOutput("reset_busy", loader_busy, 0);
    checkOutput("reset_pred_valid", pred_valid, 0);
    checkOutput("reset_tx_valid", tx_valid, 0);
    checkOutput("reset_img_we", img_we, 0);

    // Junk before the sync byte is discarded.
    applyStimulus(8'h00); applyStimulus(8'hFF); idleCycles(2);
    checkOutput("junk_no_write", weCount, 0);
    checkOutput("junk_idle", loader_busy, 0);

    // Full frame, one byte per cycle, data = address[7:0].
    applyStimulus(8'hA5);
    checkOutput("busy_after_sync", loader_busy, 1);
    for (int i = 0; i < NPIX; i++) applyStimulus(8'(i));
    idleCycles(0);
    checkOutput("last_we", img_we, 1);
    checkOutput("last_addr", img_addr, 783);
    checkOutput("last_data", img_wdata, 8'h0F);
    checkOutput("start_not_yet", start, 0);
    tick();
    checkOutput("start_rises", start, 1);
    checkOutput("frame_writes", weCount, 784);
    checkOutput("a5_as_pixel", pix165, 8'hA5);

    // Bytes during RUN are dropped.
    applyStimulus(8'h11); applyStimulus(8'hA5); idleCycles(2);
    checkOutput("run_holds_start", start, 1);
    checkOutput("run_no_write", weCount, 784);

    pred_in = 4'd7; done = 1'b1; tx_ready = 1'b0;
    tick();
    checkOutput("done_drops_start", start, 0);
    checkOutput("tx_valid_up", tx_valid, 1);
    checkOutput("tx_ascii", tx_data, 8'h37);
    checkOutput("pred_out", pred_out, 7);
    checkOutput("pred_valid", pred_valid, 1);
    pred_in = 4'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("tx_held", {tx_valid, tx_data}, {1'b1, 8'h37});
    end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    checkOutput("tx_after_hs", tx_valid, 0);

    // done still high: a new sync and payload must be ignored.
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h02); idleCycles(2);
    checkOutput("release_no_write", weCount, 784);
    checkOutput("release_busy", loader_busy, 1);
    done = 1'b0; tick();
    checkOutput("release_to_idle", loader_busy, 0);

    // Abandoned frame: 100 payload bytes then silence.
    riseSnap = startRises;
    applyStimulus(8'hA5);
    for (int i = 0; i < 100; i++) applyStimulus(8'(i + 8'h40));
    idleCycles(15);
    checkOutput("no_err_early", {frame_err, loader_busy}, 2'b01);
    tick();
    checkOutput("timeout_err", {frame_err, loader_busy}, 2'b10);
    tick();
    checkOutput("err_one_pulse", frame_err, 0);
    checkOutput("timeout_writes", weCount, 884);
    checkOutput("timeout_no_start", startRises, riseSnap);

    // Second frame with a maximal 15-cycle gap, then reset during RUN.
    applyStimulus(8'hA5);
    for (int i = 0; i < NPIX; i++) begin
      if (i == 400) idleCycles(15);
      applyStimulus(8'(i * 7 + 3));
    end
    idleCycles(2);
    checkOutput("frame2_start", start, 1);
    checkOutput("frame2_writes", weCount, 1668);
    checkOutput("pred_persists", {pred_valid, pred_out}, 5'h17);
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("rst_start", start, 0);
    checkOutput("rst_busy", loader_busy, 0);
    checkOutput("rst_pred", {pred_valid, pred_out}, 5'h00);
    done = 1'b1; pred_in = 4'd3;
    idleCycles(3);
    checkOutput("rst_no_tx", {tx_valid, start}, 2'b00);
    done = 1'b0;
    idleCycles(2);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
